// File: rtl/mult_bus_if_pkg.sv
// Shared constants for the multiplier bus interface: FSM states, register map, STATUS bits.
package mult_bus_if_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    LAUNCH  = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    DRAIN   = 3'd5
  } state_t;

  localparam logic [2:0] ADDR_A      = 3'd0;
  localparam logic [2:0] ADDR_B      = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_RESULT = 3'd4;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_DONE    = 1;
  localparam int unsigned STAT_OVERRUN = 2;
  localparam int unsigned STAT_TIMEOUT = 3;

endpackage

// File: rtl/mult_bus_if_if.sv
// Processor register bus: select, strobes, address and data.
interface mult_bus_if_if;
  logic        cs;
  logic        we;
  logic        rd;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output cs, we, rd, addr, wdata, input rdata);
  modport slave  (input cs, we, rd, addr, wdata, output rdata);
endinterface

// File: rtl/mult_bus_regfile.sv
// Operand/result registers, read mux and read-clear status flags.
// Optional MULT_TIMEOUT_EN adds the timeout flag (STATUS bit3) and folds it into irq.
module mult_bus_regfile
  import mult_bus_if_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  mult_bus_if_if.slave       bus,
  input  logic               busy,
  input  logic               capture,
  input  logic               timeout_set,
  input  logic [2*WIDTH-1:0] mult_result,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic               start,
  output logic               irq
);

  logic [2*WIDTH-1:0] result;
  logic               done;
  logic               overrun;
  logic               wr;
  logic               rd_en;
  logic               start_req;
  logic               op_ovr;
  logic               stat_rd;
  logic               timeout;
  logic [31:0]        rd_val;
  logic               unused_wdata;

  assign unused_wdata = ^bus.wdata[31:WIDTH];

  assign wr        = bus.cs & bus.we;
  assign rd_en     = bus.cs & bus.rd & ~bus.we;
  assign start_req = wr & (bus.addr == ADDR_CTRL) & bus.wdata[0];
  assign start     = start_req & ~busy;
  assign op_ovr    = wr & busy & ((bus.addr == ADDR_A) | (bus.addr == ADDR_B));
  assign stat_rd   = rd_en & (bus.addr == ADDR_STATUS);

`ifdef MULT_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout <= 1'b0;
    end else if (timeout_set) begin
      timeout <= 1'b1;
    end else if (stat_rd) begin
      timeout <= 1'b0;
    end
  end
  assign irq = done | timeout;
`else
  assign timeout = 1'b0;
  assign irq     = done;
`endif

  // STATUS shows flags being set this cycle so a coincident read never loses them
  always_comb begin
    rd_val = '0;
    case (bus.addr)
      ADDR_A:      rd_val[WIDTH-1:0] = op_a;
      ADDR_B:      rd_val[WIDTH-1:0] = op_b;
      ADDR_STATUS: begin
        rd_val[STAT_BUSY]    = busy;
        rd_val[STAT_DONE]    = done | capture;
        rd_val[STAT_OVERRUN] = overrun;
        rd_val[STAT_TIMEOUT] = timeout | timeout_set;
      end
      ADDR_RESULT: rd_val[2*WIDTH-1:0] = result;
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      result    <= '0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      if (wr && !busy && bus.addr == ADDR_A) op_a <= bus.wdata[WIDTH-1:0];
      if (wr && !busy && bus.addr == ADDR_B) op_b <= bus.wdata[WIDTH-1:0];
      if (capture)          result <= mult_result;
      else if (timeout_set) result <= '0;
      if (capture)      done <= 1'b1;
      else if (stat_rd) done <= 1'b0;
      if (op_ovr || (start_req && busy)) overrun <= 1'b1;
      else if (stat_rd)                  overrun <= 1'b0;
      if (rd_en) bus.rdata <= rd_val;
    end
  end

endmodule

// File: rtl/mult_bus_if.sv
// Bus-side controller for the sequential multiplier: start FSM plus register file.
// Optional MULT_TIMEOUT_EN bounds the wait for mult_done by TIMEOUT cycles.
module mult_bus_if
  import mult_bus_if_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  mult_bus_if_if.slave       bus,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic               init,
  input  logic               mult_done,
  input  logic [2*WIDTH-1:0] mult_result,
  output logic               irq
);

  state_t state;
  logic   busy;
  logic   start;
  logic   capture;
  logic   timeout_set;

  assign capture = (state == CAPTURE);

`ifdef MULT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  assign timeout_set = (state == WAIT) & ~mult_done & (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (state == LAUNCH) begin
      tcnt <= '0;
    end else if (state == WAIT && !mult_done) begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  localparam int unsigned unused_timeout = TIMEOUT;
  assign timeout_set = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      init  <= 1'b0;
    end else begin
      init <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= ARM;
          busy  <= 1'b1;
        end
        ARM: if (!mult_done) begin
          state <= LAUNCH;
          init  <= 1'b1;
        end
        LAUNCH: state <= WAIT;
        WAIT: begin
          if (mult_done) begin
            state <= CAPTURE;
          end else if (timeout_set) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        CAPTURE: state <= DRAIN;
        DRAIN: if (!mult_done) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  mult_bus_regfile #(.WIDTH(WIDTH)) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .capture     (capture),
    .timeout_set (timeout_set),
    .mult_result (mult_result),
    .op_a        (op_a),
    .op_b        (op_b),
    .start       (start),
    .irq         (irq)
  );

endmodule

// File: tb/tb_mult_bus_if.sv
// Directed bench for mult_bus_if with a behavioural multiplier model driving mult_done/mult_result.
module tb_mult_bus_if;
  import mult_bus_if_pkg::*;

`ifdef MULT_TIMEOUT_EN
  localparam int unsigned TMO = 10;
`else
  localparam int unsigned TMO = 1023;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] op_a, op_b;
  logic        init, mult_done, irq;
  logic [31:0] mult_result;

  mult_bus_if_if bus ();

  mult_bus_if #(.WIDTH(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .op_a(op_a), .op_b(op_b), .init(init),
    .mult_done(mult_done), .mult_result(mult_result), .irq(irq)
  );

  always #5 clk = ~clk;

  // Multiplier model: 4 cycles after init, done is held high for 31 cycles
  int          lat = 0;
  int          win = 0;
  int          init_count = 0;
  logic        model_en = 1'b1;
  logic        force_done = 1'b0;
  logic [31:0] model_res = '0;

  always @(posedge clk) begin
    if (init) init_count <= init_count + 1;
    if (init && model_en) begin
      lat       <= 4;
      model_res <= {16'h0, op_a} * {16'h0, op_b};
    end else if (lat > 0) begin
      lat <= lat - 1;
      if (lat == 1) win <= 31;
    end else if (win > 0) begin
      win <= win - 1;
    end
  end

  assign mult_done   = (win > 0) | force_done;
  assign mult_result = model_res;

  int total = 0;
  int passed = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1; bus.rd = 1'b0; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b0; bus.rd = 1'b1; bus.addr = a;
    @(negedge clk);
    bus.cs = 1'b0; bus.rd = 1'b0;
    d = bus.rdata;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (init !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check({tag, "_init_seen"}, {31'h0, init}, 32'h1);
  endtask

  task automatic wait_done_level(input string tag, input logic lvl);
    int n = 0;
    while (mult_done !== lvl && n < 200) begin @(negedge clk); n++; end
    check({tag, "_mult_done_level"}, {31'h0, mult_done}, {31'h0, lvl});
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (irq !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check({tag, "_irq_seen"}, {31'h0, irq}, 32'h1);
  endtask

  task automatic finish_run(input string tag);
    wait_irq(tag);
    wait_done_level(tag, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  int base;

  initial begin
    bus.cs = 1'b0; bus.we = 1'b0; bus.rd = 1'b0; bus.addr = '0; bus.wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_op_a", {16'h0, op_a}, 32'h0);
    check("rst_op_b", {16'h0, op_b}, 32'h0);
    check("rst_init", {31'h0, init}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    rst = 1'b0;
    read_check("rst_status", ADDR_STATUS, 32'h0);

    // Run 1: 3 * 5, init timing and read-clear of STATUS
    bus_write(ADDR_A, 32'h3);
    bus_write(ADDR_B, 32'h5);
    read_check("t1_read_a", ADDR_A, 32'h3);
    base = init_count;
    bus_write(ADDR_CTRL, 32'h1);
    check("t1_init_pre", {31'h0, init}, 32'h0);
    @(negedge clk);
    check("t1_init_hi", {31'h0, init}, 32'h1);
    @(negedge clk);
    check("t1_init_lo", {31'h0, init}, 32'h0);
    check("t1_op_a", {16'h0, op_a}, 32'h3);
    check("t1_op_b", {16'h0, op_b}, 32'h5);
    read_check("t1_status_busy", ADDR_STATUS, 32'h1);
    finish_run("t1");
    check("t1_init_count", init_count - base, 32'h1);
    read_check("t1_status_done", ADDR_STATUS, 32'h2);
    read_check("t1_status_clr", ADDR_STATUS, 32'h0);
    read_check("t1_result", ADDR_RESULT, 32'hF);
    read_check("t1_ctrl_reads0", ADDR_CTRL, 32'h0);
    read_check("t1_addr7_reads0", 3'd7, 32'h0);

    // Run 2: full-scale operands, single capture per done window
    bus_write(ADDR_A, 32'hFFFF);
    bus_write(ADDR_B, 32'h0000_FFFF);
    base = init_count;
    bus_write(ADDR_CTRL, 32'h1);
    wait_irq("t2");
    read_check("t2_status_in_window", ADDR_STATUS, 32'h3);
    wait_done_level("t2", 1'b0);
    repeat (2) @(negedge clk);
    read_check("t2_status_after", ADDR_STATUS, 32'h0);
    read_check("t2_result", ADDR_RESULT, 32'hFFFE_0001);
    check("t2_init_count", init_count - base, 32'h1);

    // Run 3: start and operand write while busy
    bus_write(ADDR_A, 32'h7);
    bus_write(ADDR_B, 32'h9);
    base = init_count;
    bus_write(ADDR_CTRL, 32'h1);
    wait_init("t3");
    bus_write(ADDR_CTRL, 32'h1);
    bus_write(ADDR_A, 32'h1234);
    check("t3_op_a_held", {16'h0, op_a}, 32'h7);
    finish_run("t3");
    check("t3_init_count", init_count - base, 32'h1);
    read_check("t3_status_ovr", ADDR_STATUS, 32'h6);
    read_check("t3_result", ADDR_RESULT, 32'h3F);

    // Run 4: mult_done ignored in IDLE; start withheld while it is high
    force_done = 1'b1;
    repeat (3) @(negedge clk);
    read_check("t4_idle_done_ignored", ADDR_STATUS, 32'h0);
    base = init_count;
    bus_write(ADDR_CTRL, 32'h1);
    repeat (5) @(negedge clk);
    check("t4_init_withheld", init_count - base, 32'h0);
    read_check("t4_status_arm", ADDR_STATUS, 32'h1);
    force_done = 1'b0;
    wait_init("t4");
    finish_run("t4");
    check("t4_init_count", init_count - base, 32'h1);
    read_check("t4_status_done", ADDR_STATUS, 32'h2);
    read_check("t4_result", ADDR_RESULT, 32'h3F);

`ifdef MULT_TIMEOUT_EN
    // Run 6: no done ever arrives; timeout after TMO wait cycles
    model_en = 1'b0;
    bus_write(ADDR_CTRL, 32'h1);
    wait_init("t6");
    repeat (10) @(negedge clk);
    check("t6_irq_before", {31'h0, irq}, 32'h0);
    @(negedge clk);
    check("t6_irq_timeout", {31'h0, irq}, 32'h1);
    read_check("t6_status", ADDR_STATUS, 32'h8);
    read_check("t6_result", ADDR_RESULT, 32'h0);
    check("t6_irq_cleared", {31'h0, irq}, 32'h0);
    model_en = 1'b1;
`endif

    // Run 5: asynchronous reset during WAIT
    bus_write(ADDR_A, 32'h2);
    bus_write(ADDR_B, 32'h3);
    read_check("t5_read_b", ADDR_B, 32'h3);
    bus_write(ADDR_CTRL, 32'h1);
    wait_init("t5");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_op_a", {16'h0, op_a}, 32'h0);
    check("t5_rst_op_b", {16'h0, op_b}, 32'h0);
    check("t5_rst_init", {31'h0, init}, 32'h0);
    check("t5_rst_irq", {31'h0, irq}, 32'h0);
    check("t5_rst_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_done_level("t5_hi", 1'b1);
    wait_done_level("t5_lo", 1'b0);
    repeat (2) @(negedge clk);
    check("t5_irq_after", {31'h0, irq}, 32'h0);
    read_check("t5_status", ADDR_STATUS, 32'h0);
    read_check("t5_result", ADDR_RESULT, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mult_bus_if.md
Name: mult_bus_if

Overview:
- Processor-side register interface for the calculator's sequential multiplier.
- Latches the two operands written by the processor and issues a one-cycle init pulse to the multiplier control unit.
- Captures the product on the first cycle of the done window, then exposes busy/done/overrun status and the result for the processor to read.
- Sits between the processor bus and the multiplier (control unit plus datapath).

Parameters:
- WIDTH, 16, operand width in bits; the product is 2*WIDTH bits and must be 2*WIDTH <= 32.
- TIMEOUT, 1023, cycles to wait for done before flagging an error (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cs  in  1  bus select.
- we  in  1  write strobe; valid when cs=1.
- rd  in  1  read strobe; valid when cs=1.
- addr  in  3  register address.
- wdata  in  32  write data.
- rdata  out  32  read data, registered.
- op_a  out  WIDTH  multiplicand held to the multiplier.
- op_b  out  WIDTH  multiplier operand held to the multiplier.
- init  out  1  start pulse to the multiplier control unit.
- mult_done  in  1  multiplier DONE; held high for about 31 cycles per operation.
- mult_result  in  2*WIDTH  multiplier product.
- irq  out  1  level interrupt; equals the done flag.

Behaviour:
- Reset: asynchronous and active-high, as already decided. Every output and register goes to 0, including op_a, op_b, init, rdata, result, flags and timeout counter. FSM goes to IDLE. Reset mid-operation abandons the operation.
- Register map (addr):
  - 0 = A, read/write, low WIDTH bits.
  - 1 = B, read/write, low WIDTH bits.
  - 2 = CTRL, write bit0=1 requests start; reads 0.
  - 3 = STATUS, read-only: bit0 busy, bit1 done, bit2 overrun, bit3 timeout. Reading it clears done, overrun and timeout.
  - 4 = RESULT, read-only, zero-extended to 32 bits.
  - 5-7: reads 0; writes ignored.
- Writes: take effect on the clock edge with cs&we. Writes to A or B while busy=1 are ignored and set overrun.
- Reads: cs&rd registers rdata on that edge (one-cycle latency). rdata holds its value otherwise.
- If we and rd are both high in the same cycle, the write has priority and rdata is unchanged.
- FSM states:
  - IDLE: busy=0. A CTRL start write moves to ARM.
  - ARM: busy=1. Waits while mult_done=1, so a prior done window drains. When mult_done=0, go to LAUNCH.
  - LAUNCH: init=1 for exactly this one cycle. Go to WAIT.
  - WAIT: busy=1. When mult_done=1, go to CAPTURE.
  - CAPTURE: result <= mult_result. done flag set one cycle after the edge (STATUS read in the same cycle sees the new flag). Go to DRAIN.
  - DRAIN: busy=1. When mult_done=0, go to IDLE. This prevents a second capture within the same done window.
- A start request while busy=1 is ignored and sets overrun.
- mult_done seen in IDLE is ignored.
- If a STATUS-read clear and a done-set land in the same cycle, the set wins.
- op_a and op_b stay stable from LAUNCH through DRAIN.
- init is never asserted in any state except LAUNCH.

Optional Feature:
- Macro MULT_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle in WAIT and clears on entering WAIT.
  - When the count reaches TIMEOUT, set the timeout flag, set result to 0 and go to IDLE without setting done.
  - irq = done | timeout.
- Undefined: no counter; WAIT waits indefinitely; STATUS bit3 reads 0; irq = done.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE, ARM, LAUNCH, WAIT, CAPTURE, DRAIN (3-bit).
  - Register address constants ADDR_A through ADDR_RESULT.
  - STATUS bit index constants.
- One natural sub-module: mult_bus_regfile, covering operand/result registers, the read mux and read-clear flags. The FSM stays in the top module.

Test Plan:
- Write A=3, B=5, CTRL=1; model done high 31 cycles after init with result 15. Expect: init high exactly 1 cycle, 2 cycles after the CTRL write; busy=1 until done falls; RESULT reads 15; STATUS reads 0x2, then 0x0 on a second read.
- A=0xFFFF, B=0xFFFF. Expect RESULT=0xFFFE0001; done window of 31 cycles produces exactly one capture.
- CTRL=1 and A-write while busy. Expect no second init, op_a unchanged, STATUS bit2=1.
- Start while mult_done is still high from a previous run. Expect init withheld until mult_done=0, then issued once.
- Assert rst during WAIT. Expect all outputs 0 immediately (asynchronous); later done is ignored; STATUS=0.
- MULT_TIMEOUT_EN with TIMEOUT=10, mult_done held 0. Expect STATUS bit3=1 and irq=1 after 10 WAIT cycles, busy=0, RESULT=0.
